// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the decoder.
// The load-use compare lives here so the decoder and controller agree on it.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Opcode / funct encodings shared with the decoder
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] JR  = 6'b001000;

    // $zero is never a real producer, so a lw targeting it cannot create a hazard
    function automatic logic load_use(
        input logic       ex_memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return ex_memread && (ex_rt != REG_ZERO) &&
               ((uses_rs && (id_rs == ex_rt)) || (uses_rt && (id_rt == ex_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and stage-control outputs of the hazard controller.
// master = pipeline datapath side, slave = the controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jal;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_redirect;
    logic             mem_access;
    logic             dmem_ready;

    logic             dmem_req;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             mem_err;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jal,
               ex_memread, ex_rt, ex_redirect, mem_access, dmem_ready,
        input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush,
               stall_cycles, flush_count, mem_err
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jal,
               ex_memread, ex_rt, ex_redirect, mem_access, dmem_ready,
        output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush,
               stall_cycles, flush_count, mem_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory freeze, redirect flush,
// load-use bubble and jal bubble, plus perf counters and a sticky memory timeout.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal issue; a pending data access without ready moves to MEM_WAIT
// MEM_WAIT | pipeline frozen on a data access; wait_cnt runs toward the timeout
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err_q;

    logic       lu;
    logic       mw;
    logic [4:0] en_raw;      // {pc, ifid, idex, exmem, memwb}
    logic       ifid_fl_raw;
    logic       idex_fl_raw;
    logic       redirect_evt;

    assign lu = load_use(hz.ex_memread, hz.ex_rt, hz.id_rs, hz.id_rt,
                         hz.id_uses_rs, hz.id_uses_rt);
    assign mw = hz.mem_access & ~hz.dmem_ready;

    // Freeze holds redirect/lu sources in place, so they re-present after the access
    always_comb begin
        en_raw       = 5'b11111;
        ifid_fl_raw  = 1'b0;
        idex_fl_raw  = 1'b0;
        redirect_evt = 1'b0;
        if (mw) begin
            en_raw = 5'b00000;
        end else if (hz.ex_redirect) begin
            ifid_fl_raw  = 1'b1;
            idex_fl_raw  = 1'b1;
            redirect_evt = 1'b1;
        end else if (lu) begin
            en_raw      = 5'b00111;
            idex_fl_raw = 1'b1;
        end else if (hz.id_jal) begin
            ifid_fl_raw = 1'b1;
        end
    end

    // Reset gating is combinational so a mid-access reset drops dmem_req at once
    assign hz.dmem_req    = rst_n & hz.mem_access;
    assign hz.pc_en       = rst_n & en_raw[4];
    assign hz.ifid_en     = rst_n & en_raw[3];
    assign hz.idex_en     = rst_n & en_raw[2];
    assign hz.exmem_en    = rst_n & en_raw[1];
    assign hz.memwb_en    = rst_n & en_raw[0];
    assign hz.ifid_flush  = ~rst_n | ifid_fl_raw;
    assign hz.idex_flush  = ~rst_n | idex_fl_raw;
    assign hz.memwb_flush = ~rst_n;
    assign hz.mem_err     = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mw) begin
                        state <= RUN;
                    end
                    // No abort on timeout: the flag only reports, the FSM keeps waiting
                    if ((wait_cnt == WAIT_TC) && !hz.dmem_ready) begin
                        mem_err_q <= 1'b1;
                    end
                    if (wait_cnt != {WAIT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~en_raw[4]),
        .cnt   (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_evt),
        .cnt   (hz.flush_count)
    );

endmodule
